// File: rtl/l1_cache_pkg.sv
// l1_cache_pkg -- shared types for the L1 cache slice.
//   lc3b_c_tag / lc3b_c_index / lc3b_c_offset / lc3b_c_line : address fields and line storage
//   cache_state_e : controller state encoding
// Optional feature macro: CACHE_PERF_EN (hit/miss counters in l1_cache).
package l1_cache_pkg;

    typedef logic [8:0]   lc3b_c_tag;     // mem_address[15:7]
    typedef logic [2:0]   lc3b_c_index;   // mem_address[6:4]
    typedef logic [2:0]   lc3b_c_offset;  // mem_address[3:1], 16-bit word within line
    typedef logic [127:0] lc3b_c_line;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_FILL
    } cache_state_e;

endpackage

// File: rtl/l1_cache_if.sv
// l1_cache_if -- CPU-side and memory-side buses of the L1 cache.
//   CPU side    : mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata -> mem_rdata, mem_resp
//   Memory side : pmem_read, pmem_write, pmem_address, pmem_wdata -> pmem_rdata, pmem_resp
//   master : the environment (CPU + physical memory)
//   slave  : the cache
interface l1_cache_if;

    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;

    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_rdata, mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_rdata, mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

endinterface

// File: rtl/l1_cache_control.sv
// cache_control -- miss-handling FSM for l1_cache (IDLE / WRITEBACK / FILL).
//   in : clk, rst_n (async, active-low), req, hit, victim_dirty, pmem_resp
//   out: mem_resp (hit in IDLE), pmem_read (FILL), pmem_write (WRITEBACK),
//        load_line (fill data returning this cycle), miss_start (IDLE leaves on a miss)
module cache_control
    import l1_cache_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic hit,
    input  logic victim_dirty,
    input  logic pmem_resp,
    output logic mem_resp,
    output logic pmem_read,
    output logic pmem_write,
    output logic load_line,
    output logic miss_start
);

    cache_state_e state, state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (req && !hit) state_nxt = victim_dirty ? S_WRITEBACK : S_FILL;
            S_WRITEBACK: if (pmem_resp)   state_nxt = S_FILL;
            S_FILL:      if (pmem_resp)   state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        load_line  = 1'b0;
        miss_start = 1'b0;
        case (state)
            S_IDLE: begin
                mem_resp   = req && hit;
                miss_start = req && !hit;
            end
            S_WRITEBACK: pmem_write = 1'b1;
            S_FILL: begin
                pmem_read = 1'b1;
                load_line = pmem_resp;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/l1_cache.sv
// l1_cache -- direct-mapped, write-back, write-allocate cache, 8 lines x 128 bits.
//   clk, rst_n    : clock, async active-low reset
//   bus (slave)   : CPU request/response and physical-memory line transfers
//   hit_count, miss_count : saturating performance counters, only with CACHE_PERF_EN
// Address: tag=[15:7], index=[6:4], word=[3:1]; bit 0 ignored.
module l1_cache
    import l1_cache_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    l1_cache_if.slave   bus
`ifdef CACHE_PERF_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    lc3b_c_tag    tag_arr  [8];
    lc3b_c_line   data_arr [8];
    logic [7:0]   valid, dirty;

    lc3b_c_tag    req_tag;
    lc3b_c_index  idx;
    lc3b_c_offset off;
    lc3b_c_line   cur_line, merged_line;
    logic         req, hit, victim_dirty, load_line, miss_start, write_hit;
    logic         unused_addr_b0;

    assign req_tag        = bus.mem_address[15:7];
    assign idx            = bus.mem_address[6:4];
    assign off            = bus.mem_address[3:1];
    assign unused_addr_b0 = bus.mem_address[0];

    assign req          = bus.mem_read || bus.mem_write;
    assign cur_line     = data_arr[idx];
    assign hit          = valid[idx] && (tag_arr[idx] == req_tag);
    assign victim_dirty = valid[idx] && dirty[idx];

    cache_control u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .hit          (hit),
        .victim_dirty (victim_dirty),
        .pmem_resp    (bus.pmem_resp),
        .mem_resp     (bus.mem_resp),
        .pmem_read    (bus.pmem_read),
        .pmem_write   (bus.pmem_write),
        .load_line    (load_line),
        .miss_start   (miss_start)
    );

    // Read+write together is a write, so it returns no data.
    assign write_hit     = bus.mem_resp && bus.mem_write;
    assign bus.mem_rdata = (bus.mem_resp && !bus.mem_write) ? cur_line[{off, 4'd0} +: 16] : 16'h0;

    always_comb begin
        merged_line = cur_line;
        if (bus.mem_byte_enable[0]) merged_line[{off, 4'd0} +: 8] = bus.mem_wdata[7:0];
        if (bus.mem_byte_enable[1]) merged_line[{off, 4'd8} +: 8] = bus.mem_wdata[15:8];
    end

    // Writeback targets the resident line; everything else addresses the request's line.
    assign bus.pmem_address = bus.pmem_write ? {tag_arr[idx], idx, 4'h0} : {req_tag, idx, 4'h0};
    assign bus.pmem_wdata   = cur_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (load_line) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (write_hit) begin
            dirty[idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: valid gates every use. load_line is forced low
    // by reset, so an aborted fill leaves the line untouched.
    always_ff @(posedge clk) begin
        if (load_line) begin
            tag_arr[idx]  <= req_tag;
            data_arr[idx] <= bus.pmem_rdata;
        end else if (write_hit) begin
            data_arr[idx] <= merged_line;
        end
    end

`ifdef CACHE_PERF_EN
    // A request that missed is answered later as a hit; it must not count as one.
    logic missed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            missed     <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (miss_start) begin
                missed <= 1'b1;
                if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
            end
            if (bus.mem_resp) begin
                missed <= 1'b0;
                if (!missed && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/l1_cache.md
L1_CACHE -- requirements
Module: l1_cache

Interface
REQ-001 The block SHALL have the ports: clk input 1, single clock, all state updates on rising edge.
REQ-002 The block SHALL have the port: rst_n input 1, reset, asynchronous, active-low.
REQ-003 The block SHALL have the CPU-side ports: mem_read input 1; mem_write input 1; mem_byte_enable input 2 ([1]=high byte); mem_address input 16; mem_wdata input 16.
REQ-004 The block SHALL have the CPU-side outputs: mem_rdata output 16; mem_resp output 1.
REQ-005 The block SHALL have the memory-side ports: pmem_read output 1; pmem_write output 1; pmem_address output 16 (line-aligned, [3:0]=0); pmem_wdata output 128; pmem_rdata input 128; pmem_resp input 1.
REQ-006 The block SHALL have counter outputs hit_count output 16 and miss_count output 16, present only under CACHE_PERF_EN.

Function
REQ-007 The block SHALL be a direct-mapped, write-back, write-allocate cache with 8 lines of 128 bits.
REQ-008 Address split SHALL be tag=[15:7] (9b), index=[6:4], word offset=[3:1]; mem_address[0] is ignored.
REQ-009 Per line, the block SHALL hold valid, dirty, tag and a 128-bit data word.
REQ-010 The FSM SHALL have states IDLE, WRITEBACK and FILL.
REQ-011 In IDLE with a request and a hit (valid and tag match), mem_resp SHALL be asserted combinationally in the same cycle.
REQ-012 On a read hit, mem_rdata SHALL equal the addressed 16-bit word of the line.
REQ-013 On a write hit, only the bytes enabled by mem_byte_enable SHALL be written at the next edge, and dirty SHALL be set.
REQ-014 In IDLE on a miss, the FSM SHALL go to WRITEBACK if the victim is valid and dirty, otherwise to FILL.
REQ-015 In WRITEBACK, pmem_write SHALL be 1, pmem_address SHALL be {victim tag, index, 4'b0} and pmem_wdata the victim line; the FSM SHALL stay until pmem_resp, then go to FILL.
REQ-016 In FILL, pmem_read SHALL be 1 and pmem_address {req tag, index, 4'b0}; on pmem_resp the line SHALL load pmem_rdata with valid=1, dirty=0, tag=req tag, and the FSM SHALL go to IDLE.
REQ-017 On return to IDLE the held request SHALL hit and be serviced per REQ-011..013.
REQ-018 mem_resp SHALL be 0 in WRITEBACK and FILL; pmem_read and pmem_write SHALL never be 1 together.
REQ-019 The CPU holds its request stable until mem_resp; with no request, IDLE SHALL not change any state.
REQ-020 mem_read and mem_write both 1 SHALL be treated as a write.
REQ-021 mem_rdata SHALL be 0 when not responding to a read.

Reset
REQ-022 rst_n low SHALL immediately force IDLE and clear all valid and dirty bits.
REQ-023 rst_n low SHALL drive mem_resp, pmem_read and pmem_write to 0 and zero the counters.
REQ-024 Reset during WRITEBACK or FILL SHALL abort the transfer with no line update; data and tag arrays need not be cleared.

Configuration
REQ-025 With CACHE_PERF_EN defined, miss_count SHALL increment on each IDLE->WRITEBACK/FILL transition.
REQ-026 With CACHE_PERF_EN defined, hit_count SHALL increment on each mem_resp of a request that did not miss; both counters saturate at 16'hFFFF.
REQ-027 Without CACHE_PERF_EN, the counters and ports SHALL be absent and behaviour otherwise identical.

Structure
REQ-028 lc3b_types SHALL add lc3b_c_tag (9b), lc3b_c_index (3b), lc3b_c_offset (3b) and lc3b_c_line (128b).
REQ-029 The block SHALL be split into one FSM sub-module, cache_control, plus arrays/muxing in l1_cache.

Verification
REQ-030 After reset, read 0x0102 -> FILL with pmem_address 0x0100; pmem_rdata word1=0xBEEF -> mem_resp with mem_rdata 0xBEEF, miss_count=1.
REQ-031 Repeat read 0x0102 -> mem_resp in the same cycle, no pmem activity, hit_count=1.
REQ-032 Write 0x0104 data 0x1234 with mem_byte_enable=2'b01, then read 0x0104 -> 0xXX34 (high byte from fill), dirty=1.
REQ-033 Read 0x0184 (same index, new tag) -> WRITEBACK at 0x0100 with the modified line, then FILL at 0x0180, then resp.
REQ-034 pmem_resp delayed 5 cycles in FILL -> pmem_read held 5 cycles with mem_resp 0 throughout.
REQ-035 rst_n low mid-FILL -> pmem_read 0 immediately; subsequent read of the same address misses again.
